// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup and EM-side resolution signals of the branch predictor.
// Handshake: no valid/ready. pred_oe qualifies a lookup, whose result appears one edge later. upd_we qualifies a single-cycle resolution that is always accepted.
interface branch_predict_unit_if #(
    parameter int GHR_W = 8
);
    localparam int INFO_W = 2 + ((GHR_W > 0) ? GHR_W : 1);

    logic              init_busy;
    logic              dbg_state;
    logic              pred_oe;
    logic [31:0]       pred_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic [INFO_W-1:0] pred_info;
    logic              upd_we;
    logic [31:0]       upd_pc;
    logic [1:0]        upd_kind;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic [INFO_W-1:0] upd_info;

    modport master (
        input  init_busy, dbg_state, pred_taken, pred_target, pred_info,
        output pred_oe, pred_pc, upd_we, upd_pc, upd_kind, upd_taken, upd_target, upd_info
    );

    modport slave (
        output init_busy, dbg_state, pred_taken, pred_target, pred_info,
        input  pred_oe, pred_pc, upd_we, upd_pc, upd_kind, upd_taken, upd_target, upd_info
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Front-end predictor: tagged BTB, 2-bit PHT (bimodal or gshare), and a non-speculative return stack.
// Lookups answer one cycle after IF. Tables are cleared one entry per cycle after reset.
module branch_predict_unit #(
    parameter int IDX_W     = 10,
    parameter int TAG_W     = 8,
    parameter int GHR_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_predict_unit_if.slave  bus
);
    localparam int GHW     = (GHR_W > 0) ? GHR_W : 1;
    localparam int INFO_W  = 2 + GHW;
    localparam int ENTRIES = 1 << IDX_W;
    localparam int RAS_N   = (RAS_DEPTH > 0) ? RAS_DEPTH : 1;
    localparam int RAS_PW  = (RAS_N > 1) ? $clog2(RAS_N) : 1;
    localparam int RAS_CW  = $clog2(RAS_N + 1);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_clr_ptr;
    logic [GHW-1:0]    r_ghr;
    logic              w_run;
    logic              w_upd;

    logic              r_btb_valid [0:ENTRIES-1];
    logic [TAG_W-1:0]  r_btb_tag   [0:ENTRIES-1];
    logic [1:0]        r_btb_kind  [0:ENTRIES-1];
    logic [31:0]       r_btb_tgt   [0:ENTRIES-1];
    logic [1:0]        r_pht       [0:ENTRIES-1];

    logic [IDX_W-1:0]  w_lk_set, w_lk_pht, w_upd_set, w_upd_pht;
    logic [TAG_W-1:0]  w_lk_tag, w_upd_tag;
    logic              w_hit, w_taken, w_ras_nz;
    logic [1:0]        w_ctr, w_kind, w_upd_ctr_old, w_upd_ctr_new;
    logic [31:0]       w_tgt, w_ras_top;

    logic              r_pred_taken;
    logic [31:0]       r_pred_target;
    logic [INFO_W-1:0] r_pred_info;
    logic              w_unused;

    // Assertion is immediate; release is delayed two edges so INIT starts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= S_INIT;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (&r_clr_ptr) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    assign w_run         = (r_state == S_RUN);
    assign w_upd         = w_run & bus.upd_we;
    assign bus.init_busy = w_rst_n & (r_state == S_INIT);
    assign bus.dbg_state = w_run;

    // History folds into the low min(GHR_W, IDX_W) index bits.
    function automatic logic [IDX_W-1:0] fold(input logic [GHW-1:0] h);
        logic [GHW+IDX_W-1:0] ext;
        ext = {{IDX_W{1'b0}}, h};
        if (GHR_W == 0) return '0;
        return ext[IDX_W-1:0];
    endfunction

    assign w_lk_set = bus.pred_pc[2 +: IDX_W];
    assign w_lk_tag = bus.pred_pc[2 + IDX_W +: TAG_W];
    assign w_lk_pht = w_lk_set ^ fold(r_ghr);
    assign w_hit    = r_btb_valid[w_lk_set] && (r_btb_tag[w_lk_set] == w_lk_tag);
    assign w_ctr    = r_pht[w_lk_pht];
    assign w_kind   = r_btb_kind[w_lk_set];
    assign w_taken  = w_hit && ((w_kind != 2'b00) || w_ctr[1]);
    assign w_tgt    = !w_hit ? 32'd0 :
                      ((w_kind == 2'b11) && w_ras_nz) ? w_ras_top : r_btb_tgt[w_lk_set];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_pred_info   <= '0;
        end else if (bus.pred_oe) begin
            if (w_run) begin
                r_pred_taken  <= w_taken;
                r_pred_target <= {w_tgt[31:1], 1'b0};
                r_pred_info   <= {w_ctr, r_ghr};
            end else begin
                r_pred_taken  <= 1'b0;
                r_pred_target <= '0;
                r_pred_info   <= '0;
            end
        end
    end

    assign bus.pred_taken  = r_pred_taken;
    assign bus.pred_target = r_pred_target;
    assign bus.pred_info   = r_pred_info;

    assign w_upd_set     = bus.upd_pc[2 +: IDX_W];
    assign w_upd_tag     = bus.upd_pc[2 + IDX_W +: TAG_W];
    assign w_upd_ctr_old = bus.upd_info[INFO_W-1 -: 2];
    assign w_upd_pht     = w_upd_set ^ fold(bus.upd_info[GHW-1:0]);

    always_comb begin
        w_upd_ctr_new = w_upd_ctr_old;
        if (bus.upd_taken) begin
            if (w_upd_ctr_old != 2'b11) w_upd_ctr_new = w_upd_ctr_old + 2'd1;
        end else begin
            if (w_upd_ctr_old != 2'b00) w_upd_ctr_new = w_upd_ctr_old - 2'd1;
        end
    end

    // Table storage: clear sweep during INIT, resolution writes during RUN.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_btb_valid[r_clr_ptr] <= 1'b0;
            r_pht[r_clr_ptr]       <= 2'b01;
        end else if (bus.upd_we) begin
            if (bus.upd_kind == 2'b00) r_pht[w_upd_pht] <= w_upd_ctr_new;
            if (bus.upd_taken) begin
                r_btb_valid[w_upd_set] <= 1'b1;
                r_btb_tag[w_upd_set]   <= w_upd_tag;
                r_btb_kind[w_upd_set]  <= bus.upd_kind;
                r_btb_tgt[w_upd_set]   <= {bus.upd_target[31:1], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ghr <= '0;
        end else if (w_upd && (bus.upd_kind == 2'b00) && (GHR_W > 0)) begin
            r_ghr <= GHW'({r_ghr, bus.upd_taken});
        end
    end

    generate
        if (RAS_DEPTH > 0) begin : g_ras
            logic [31:0]       r_ras [0:RAS_N-1];
            logic [RAS_PW-1:0] r_ras_ptr;
            logic [RAS_CW-1:0] r_ras_cnt;
            logic [RAS_PW-1:0] w_ptr_inc, w_ptr_dec;
            logic              w_push, w_pop;

            assign w_push    = w_upd && (bus.upd_kind == 2'b10);
            assign w_pop     = w_upd && (bus.upd_kind == 2'b11) && (r_ras_cnt != '0);
            assign w_ptr_inc = (r_ras_ptr == RAS_PW'(RAS_N - 1)) ? '0 : r_ras_ptr + 1'b1;
            assign w_ptr_dec = (r_ras_ptr == '0) ? RAS_PW'(RAS_N - 1) : r_ras_ptr - 1'b1;
            assign w_ras_top = r_ras[w_ptr_dec];
            assign w_ras_nz  = (r_ras_cnt != '0);

            // Pointer marks the next free slot; a push when full overwrites the oldest.
            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_ras_ptr <= '0;
                    r_ras_cnt <= '0;
                end else if (w_push) begin
                    r_ras_ptr <= w_ptr_inc;
                    if (r_ras_cnt != RAS_CW'(RAS_N)) r_ras_cnt <= r_ras_cnt + 1'b1;
                end else if (w_pop) begin
                    r_ras_ptr <= w_ptr_dec;
                    r_ras_cnt <= r_ras_cnt - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push) r_ras[r_ras_ptr] <= bus.upd_pc + 32'd4;
            end
        end else begin : g_no_ras
            assign w_ras_top = '0;
            assign w_ras_nz  = 1'b0;
        end
    endgenerate

    assign w_unused = ^{bus.pred_pc, bus.upd_pc, bus.upd_target[0], bus.upd_info};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: bimodal instance (GHR_W=0) for BTB/PHT/RAS and reset behaviour,
// gshare instance (GHR_W=2) for history-indexed prediction of an alternating branch.
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.GHR_W(0)) ifa ();
    branch_predict_unit_if #(.GHR_W(2)) ifb ();

    branch_predict_unit #(.IDX_W(4), .TAG_W(8), .GHR_W(0), .RAS_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    branch_predict_unit #(.IDX_W(4), .TAG_W(8), .GHR_W(2), .RAS_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    typedef struct {
        logic        upd_we;
        logic [31:0] upd_pc;
        logic [1:0]  upd_kind;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic [2:0]  upd_info;
        logic        oe;
        logic [31:0] pc;
        logic        chk;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [1:0]  exp_ctr;
    } vec_t;

    logic [34:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    vec_t tbl[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.upd_we = 0; v.upd_pc = 0; v.upd_kind = 0; v.upd_taken = 0; v.upd_target = 0;
        v.upd_info = 0; v.oe = 0; v.pc = 0; v.chk = 0; v.exp_taken = 0; v.exp_target = 0;
        v.exp_ctr = 0;
        return v;
    endfunction

    function automatic vec_t mk_upd(input logic [31:0] pc, input logic [1:0] kind, input logic tk,
                                    input logic [31:0] tgt, input logic [2:0] info);
        vec_t v;
        v = blank();
        v.upd_we = 1; v.upd_pc = pc; v.upd_kind = kind; v.upd_taken = tk;
        v.upd_target = tgt; v.upd_info = info;
        return v;
    endfunction

    function automatic vec_t mk_lk(input logic [31:0] pc, input logic et, input logic [31:0] etgt,
                                   input logic [1:0] ectr);
        vec_t v;
        v = blank();
        v.oe = 1; v.pc = pc; v.chk = 1; v.exp_taken = et; v.exp_target = etgt; v.exp_ctr = ectr;
        return v;
    endfunction

    task automatic compare_out(input string name, input logic tk, input logic [31:0] tgt,
                               input logic [1:0] ctr);
        logic [34:0] e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty, got %h expected entry", name, tgt);
        end else begin
            e = exp_q.pop_front();
            check({name, ".taken"}, 32'(tk), 32'(e[34]));
            check({name, ".target"}, tgt, e[33:2]);
            check({name, ".ctr"}, 32'(ctr), 32'(e[1:0]));
        end
    endtask

    task automatic run_a(input vec_t v, input string name);
        @(negedge clk);
        ifa.upd_we = v.upd_we; ifa.upd_pc = v.upd_pc; ifa.upd_kind = v.upd_kind;
        ifa.upd_taken = v.upd_taken; ifa.upd_target = v.upd_target; ifa.upd_info = v.upd_info;
        ifa.pred_oe = v.oe; ifa.pred_pc = v.pc;
        if (v.chk) exp_q.push_back({v.exp_taken, v.exp_target, v.exp_ctr});
        @(posedge clk); #1;
        ifa.upd_we = 0; ifa.pred_oe = 0;
        if (v.chk) compare_out(name, ifa.pred_taken, ifa.pred_target, ifa.pred_info[2:1]);
    endtask

    task automatic measure_init(output int lat, output int len, output logic mid_taken,
                                output logic [31:0] mid_tgt, output logic [2:0] mid_info);
        lat = 0; len = 0; mid_taken = 1; mid_tgt = '1; mid_info = '1;
        while (!ifa.init_busy && lat < 20) begin @(posedge clk); #1; lat++; end
        while (ifa.init_busy && len < 100) begin
            if (len == 8) begin
                mid_taken = ifa.pred_taken; mid_tgt = ifa.pred_target; mid_info = ifa.pred_info;
            end
            @(posedge clk); #1; len++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int lat, len;
        logic mid_taken;
        logic [31:0] mid_tgt;
        logic [2:0] mid_info;
        logic outcome;
        logic [3:0] b_info;

        tbl[0]  = mk_lk(32'h100, 0, 32'h0, 2'b01);
        tbl[1]  = mk_upd(32'h40, 2'b00, 1, 32'h80, 3'b010);
        tbl[2]  = mk_upd(32'h40, 2'b00, 1, 32'h80, 3'b100);
        tbl[3]  = mk_lk(32'h40, 1, 32'h80, 2'b11);
        tbl[4]  = mk_upd(32'h40, 2'b00, 0, 32'h1234, 3'b110);
        tbl[5]  = mk_upd(32'h40, 2'b00, 0, 32'h1234, 3'b100);
        tbl[6]  = mk_lk(32'h40, 0, 32'h80, 2'b01);
        tbl[7]  = mk_lk(32'h100, 0, 32'h0, 2'b01);
        tbl[8]  = mk_upd(32'h304, 2'b11, 1, 32'h999, 3'b010);
        tbl[9]  = mk_lk(32'h304, 1, 32'h998, 2'b01);
        tbl[10] = mk_upd(32'h200, 2'b10, 1, 32'h501, 3'b010);
        tbl[11] = mk_lk(32'h304, 1, 32'h204, 2'b01);
        tbl[12] = mk_lk(32'h200, 1, 32'h500, 2'b01);
        tbl[13] = mk_lk(32'h304, 1, 32'h204, 2'b01);
        tbl[13].upd_we = 1; tbl[13].upd_pc = 32'h304; tbl[13].upd_kind = 2'b11;
        tbl[13].upd_taken = 1; tbl[13].upd_target = 32'h999; tbl[13].upd_info = 3'b010;
        tbl[14] = mk_lk(32'h304, 1, 32'h998, 2'b01);
        tbl[15] = mk_lk(32'h40, 0, 32'h0, 2'b01);
        tbl[15].upd_we = 1; tbl[15].upd_pc = 32'h40; tbl[15].upd_kind = 2'b00;
        tbl[15].upd_taken = 1; tbl[15].upd_target = 32'h80; tbl[15].upd_info = 3'b010;
        tbl[16] = mk_lk(32'h40, 1, 32'h80, 2'b10);
        tbl[17] = mk_lk(32'h100, 1, 32'h80, 2'b10);
        tbl[17].oe = 0;
        tbl[18] = mk_upd(32'hFFFF_FFFC, 2'b10, 1, 32'h10, 3'b010);
        tbl[19] = mk_lk(32'h304, 1, 32'h0, 2'b01);
        tbl[20] = mk_upd(32'h304, 2'b11, 1, 32'h999, 3'b010);
        tbl[21] = mk_lk(32'h304, 1, 32'h998, 2'b01);

        ifa.pred_oe = 0; ifa.pred_pc = 0; ifa.upd_we = 0; ifa.upd_pc = 0; ifa.upd_kind = 0;
        ifa.upd_taken = 0; ifa.upd_target = 0; ifa.upd_info = 0;
        ifb.pred_oe = 0; ifb.pred_pc = 0; ifb.upd_we = 0; ifb.upd_pc = 0; ifb.upd_kind = 0;
        ifb.upd_taken = 0; ifb.upd_target = 0; ifb.upd_info = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(ifa.init_busy), 32'd0);
        check("rst.taken", 32'(ifa.pred_taken), 32'd0);
        check("rst.target", ifa.pred_target, 32'd0);

        @(negedge clk);
        rst_n = 1;
        ifa.pred_oe = 1; ifa.pred_pc = 32'h100;
        measure_init(lat, len, mid_taken, mid_tgt, mid_info);
        ifa.pred_oe = 0;
        check("init.latency", 32'(lat), 32'd2);
        check("init.length", 32'(len), 32'd16);
        check("init.lk_taken", 32'(mid_taken), 32'd0);
        check("init.lk_info", 32'(mid_info), 32'd0);
        check("init.run_state", 32'(ifa.dbg_state), 32'd1);

        for (int i = 0; i < 22; i++) run_a(tbl[i], $sformatf("vec%0d", i));

        // Five calls into a 4-deep stack, then five pops via the return at 0x304.
        for (int k = 1; k <= 5; k++)
            run_a(mk_upd(32'h1000 * k, 2'b10, 1, 32'h40, 3'b010), "ras_call");
        for (int k = 5; k >= 2; k--) begin
            run_a(mk_lk(32'h304, 1, 32'h1000 * k + 32'h4, 2'b01), $sformatf("ras_top%0d", k));
            run_a(mk_upd(32'h304, 2'b11, 1, 32'h999, 3'b010), "ras_pop");
        end
        run_a(mk_lk(32'h304, 1, 32'h998, 2'b01), "ras_empty");
        run_a(mk_upd(32'h304, 2'b11, 1, 32'h999, 3'b010), "ras_pop5");
        run_a(mk_lk(32'h304, 1, 32'h998, 2'b01), "ras_noop");
        run_a(mk_upd(32'h7000, 2'b10, 1, 32'h40, 3'b010), "ras_call7");
        run_a(mk_lk(32'h304, 1, 32'h7004, 2'b01), "ras_after");

        // Alternating T,N branch through the gshare instance, closing the info loop.
        for (int i = 0; i < 16; i++) begin
            outcome = (i % 2 == 0);
            @(negedge clk);
            ifb.pred_oe = 1; ifb.pred_pc = 32'h40;
            if (i >= 6) exp_q.push_back({outcome, 32'h80, outcome ? 2'b11 : 2'b00});
            @(posedge clk); #1;
            ifb.pred_oe = 0;
            b_info = ifb.pred_info;
            if (i >= 6) begin
                compare_out($sformatf("gshare%0d", i), ifb.pred_taken, ifb.pred_target, b_info[3:2]);
                check($sformatf("gshare%0d.ghr", i), 32'(b_info[1:0]), outcome ? 32'd2 : 32'd1);
            end
            @(negedge clk);
            ifb.upd_we = 1; ifb.upd_pc = 32'h40; ifb.upd_kind = 2'b00; ifb.upd_taken = outcome;
            ifb.upd_target = 32'h80; ifb.upd_info = b_info;
            @(posedge clk); #1;
            ifb.upd_we = 0;
        end

        // Asynchronous reset while a taken prediction is on the outputs.
        run_a(mk_lk(32'h304, 1, 32'h7004, 2'b01), "pre_reset");
        #2;
        rst_n = 0;
        #1;
        check("async.taken", 32'(ifa.pred_taken), 32'd0);
        check("async.target", ifa.pred_target, 32'd0);
        check("async.info", 32'(ifa.pred_info), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        ifa.pred_oe = 1; ifa.pred_pc = 32'h304;
        measure_init(lat, len, mid_taken, mid_tgt, mid_info);
        check("reinit.latency", 32'(lat), 32'd2);
        check("reinit.length", 32'(len), 32'd16);
        check("reinit.lk_taken", 32'(mid_taken), 32'd0);
        check("reinit.lk_target", mid_tgt, 32'd0);
        @(posedge clk); #1;
        ifa.pred_oe = 0;
        check("reinit.miss_taken", 32'(ifa.pred_taken), 32'd0);
        check("reinit.miss_target", ifa.pred_target, 32'd0);
        check("reinit.miss_info", 32'(ifa.pred_info), 32'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
